// File: rtl/dunit_pkg.sv
// Shared definitions for the pipeline debug unit: command bytes, FSM state encoding, word geometry.
package dunit_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_PC   = 8'h50;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] CMD_HALT = 8'h48;

    localparam int unsigned NB_REG_DEF = 32;

    function automatic int unsigned bytes_per_word(input int unsigned nb_reg);
        return nb_reg / 8;
    endfunction

    localparam int unsigned BYTES_PER_WORD = bytes_per_word(NB_REG_DEF);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_CNT,
        ST_LD_WORD,
        ST_LD_WR,
        ST_PC_RST,
        ST_STEP,
        ST_RUN,
        ST_DMP_ADDR,
        ST_DMP_CAP,
        ST_DMP_SEND
    } state_e;

    typedef enum logic [1:0] {
        PH_REG,
        PH_MEM,
        PH_CNT
    } dump_phase_e;

endpackage

// File: rtl/dunit_word_tx.sv
// Word-to-byte serializer: emits a loaded word MSB byte first over a valid/ready handshake,
// pulsing o_done the cycle after the last byte is accepted.
module dunit_word_tx
    import dunit_pkg::*;
#(
    parameter int unsigned NB_WORD = BYTES_PER_WORD * 8,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_WORD-1:0] i_word,
    input  logic               i_ready,
    output logic [NB_BYTE-1:0] o_data,
    output logic               o_valid,
    output logic               o_done
);

    localparam int unsigned N_BYTES = NB_WORD / NB_BYTE;

    logic [NB_WORD-1:0] shreg;
    logic [7:0]         cnt;

    assign o_data = shreg[NB_WORD-1 -: NB_BYTE];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shreg   <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_load) begin
                shreg   <= i_word;
                cnt     <= '0;
                o_valid <= 1'b1;
            end else if (o_valid && i_ready) begin
                if (cnt == 8'(N_BYTES - 1)) begin
                    o_valid <= 1'b0;
                    o_done  <= 1'b1;
                end else begin
                    shreg <= shreg << NB_BYTE;
                    cnt   <= cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/dunit_ctrl.sv
// Byte-stream debug controller for the MIPS pipeline debug port: load imem, reset PC, step/run, dump.
// Optional DUNIT_CYCLE_CNT_EN appends a saturating clk_en-cycle counter word to every dump.
module dunit_ctrl
    import dunit_pkg::*;
#(
    parameter int unsigned NB_REG     = 32,
    parameter int unsigned NB_WIDHT   = 9,
    parameter int unsigned NB_BYTE    = 8,
    parameter int unsigned N_REGS     = 32,
    parameter int unsigned DMEM_WORDS = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    output logic [NB_BYTE-1:0]  o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    input  logic                i_halt,
    input  logic [NB_REG-1:0]   i_dunit_reg,
    input  logic [NB_REG-1:0]   i_dunit_mem_data,
    output logic                o_dunit_clk_en,
    output logic                o_dunit_reset_pc,
    output logic                o_dunit_w_mem,
    output logic [NB_WIDHT-1:0] o_dunit_addr,
    output logic [NB_REG-1:0]   o_dunit_data_if
);

    localparam int unsigned BPW = bytes_per_word(NB_REG);

    state_e                 state;
    dump_phase_e            phase;
    logic [7:0]             byte_cnt;
    logic [NB_BYTE-1:0]     cnt_hi;
    logic [2*NB_BYTE-1:0]   ld_n;
    logic [2*NB_BYTE-1:0]   ld_k;
    logic [NB_REG-1:0]      ld_shift;
    logic [15:0]            dmp_idx;
    logic                   clk_en_q;
    logic                   tx_load;
    logic [NB_REG-1:0]      tx_word;
    logic                   tx_done;
    logic                   rx_halt;
    logic                   run_gate;

    // RUN enable is gated combinationally so halt or 'H' stops the pipeline in the same cycle.
    assign rx_halt        = i_rx_valid && (i_rx_data == CMD_HALT);
    assign run_gate       = (state == ST_RUN) && !i_halt && !rx_halt;
    assign o_dunit_clk_en = clk_en_q | run_gate;

`ifdef DUNIT_CYCLE_CNT_EN
    logic [NB_REG-1:0] cyc_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cyc_cnt <= '0;
        end else if (state == ST_IDLE && i_rx_valid && i_rx_data == CMD_PC) begin
            cyc_cnt <= '0;
        end else if (o_dunit_clk_en && cyc_cnt != '1) begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state            <= ST_IDLE;
            phase            <= PH_REG;
            byte_cnt         <= '0;
            cnt_hi           <= '0;
            ld_n             <= '0;
            ld_k             <= '0;
            ld_shift         <= '0;
            dmp_idx          <= '0;
            clk_en_q         <= 1'b0;
            tx_load          <= 1'b0;
            tx_word          <= '0;
            o_dunit_reset_pc <= 1'b0;
            o_dunit_w_mem    <= 1'b0;
            o_dunit_addr     <= '0;
            o_dunit_data_if  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                byte_cnt <= '0;
                                state    <= ST_LD_CNT;
                            end
                            CMD_PC: begin
                                o_dunit_reset_pc <= 1'b1;
                                state            <= ST_PC_RST;
                            end
                            CMD_STEP: begin
                                clk_en_q <= 1'b1;
                                state    <= ST_STEP;
                            end
                            CMD_RUN: state <= ST_RUN;
                            CMD_DUMP: begin
                                phase        <= PH_REG;
                                dmp_idx      <= '0;
                                o_dunit_addr <= '0;
                                state        <= ST_DMP_ADDR;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LD_CNT: begin
                    if (i_rx_valid) begin
                        if (byte_cnt == '0) begin
                            cnt_hi   <= i_rx_data;
                            byte_cnt <= 8'd1;
                        end else begin
                            ld_n     <= {cnt_hi, i_rx_data};
                            ld_k     <= '0;
                            byte_cnt <= '0;
                            state    <= ({cnt_hi, i_rx_data} == '0) ? ST_IDLE : ST_LD_WORD;
                        end
                    end
                end
                ST_LD_WORD: begin
                    if (i_rx_valid) begin
                        ld_shift <= {ld_shift[NB_REG-NB_BYTE-1:0], i_rx_data};
                        if (byte_cnt == 8'(BPW - 1)) begin
                            byte_cnt        <= '0;
                            o_dunit_w_mem   <= 1'b1;
                            o_dunit_addr    <= NB_WIDHT'({ld_k, 2'b00});
                            o_dunit_data_if <= {ld_shift[NB_REG-NB_BYTE-1:0], i_rx_data};
                            state           <= ST_LD_WR;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                ST_LD_WR: begin
                    o_dunit_w_mem <= 1'b0;
                    if (ld_k == ld_n - 1'b1) begin
                        state <= ST_IDLE;
                    end else begin
                        ld_k  <= ld_k + 1'b1;
                        state <= ST_LD_WORD;
                    end
                end
                ST_PC_RST: begin
                    o_dunit_reset_pc <= 1'b0;
                    state            <= ST_IDLE;
                end
                ST_STEP: begin
                    clk_en_q     <= 1'b0;
                    phase        <= PH_REG;
                    dmp_idx      <= '0;
                    o_dunit_addr <= '0;
                    state        <= ST_DMP_ADDR;
                end
                ST_RUN: begin
                    if (i_halt || rx_halt) begin
                        phase        <= PH_REG;
                        dmp_idx      <= '0;
                        o_dunit_addr <= '0;
                        state        <= ST_DMP_ADDR;
                    end
                end
                ST_DMP_ADDR: state <= ST_DMP_CAP;
                ST_DMP_CAP: begin
                    case (phase)
                        PH_REG:  tx_word <= i_dunit_reg;
                        PH_MEM:  tx_word <= i_dunit_mem_data;
`ifdef DUNIT_CYCLE_CNT_EN
                        default: tx_word <= cyc_cnt;
`else
                        default: tx_word <= '0;
`endif
                    endcase
                    tx_load <= 1'b1;
                    state   <= ST_DMP_SEND;
                end
                ST_DMP_SEND: begin
                    tx_load <= 1'b0;
                    if (tx_done) begin
                        state <= ST_DMP_ADDR;
                        if (phase == PH_REG && dmp_idx != 16'(N_REGS - 1)) begin
                            dmp_idx      <= dmp_idx + 16'd1;
                            o_dunit_addr <= NB_WIDHT'(dmp_idx + 16'd1);
                        end else if (phase == PH_REG) begin
                            phase        <= PH_MEM;
                            dmp_idx      <= '0;
                            o_dunit_addr <= '0;
                        end else if (phase == PH_MEM && dmp_idx != 16'(DMEM_WORDS - 1)) begin
                            dmp_idx      <= dmp_idx + 16'd1;
                            o_dunit_addr <= NB_WIDHT'(dmp_idx + 16'd1);
`ifdef DUNIT_CYCLE_CNT_EN
                        end else if (phase == PH_MEM) begin
                            phase        <= PH_CNT;
                            dmp_idx      <= '0;
                            o_dunit_addr <= '0;
`endif
                        end else begin
                            o_dunit_addr <= '0;
                            state        <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    dunit_word_tx #(
        .NB_WORD (NB_REG),
        .NB_BYTE (NB_BYTE)
    ) u_word_tx (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (tx_load),
        .i_word  (tx_word),
        .i_ready (i_tx_ready),
        .o_data  (o_tx_data),
        .o_valid (o_tx_valid),
        .o_done  (tx_done)
    );

endmodule
